// File: rtl/symbol_search_dec_if.sv
// rtl/symbol_search_dec_if.sv - request, CDF-memory and result signals of the symbol search stage
interface symbol_search_dec_if #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4,
  parameter int CDF_WIDTH    = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [RANGE_WIDTH-1:0]  RNG;
  logic [RANGE_WIDTH-1:0]  DIF_TOP;
  logic [SYMBOL_WIDTH:0]   NSYMS;
  logic                    cdf_rd_en;
  logic [SYMBOL_WIDTH-1:0] cdf_addr;
  logic [CDF_WIDTH-1:0]    cdf_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SYMBOL_WIDTH-1:0] out_symbol;
  logic [RANGE_WIDTH-1:0]  out_u;
  logic [RANGE_WIDTH-1:0]  out_v;
  logic [RANGE_WIDTH-1:0]  out_rng;

  modport slave (
    input  in_valid, RNG, DIF_TOP, NSYMS, cdf_data, out_ready,
    output in_ready, cdf_rd_en, cdf_addr, out_valid, out_symbol, out_u, out_v, out_rng
  );

  modport master (
    output in_valid, RNG, DIF_TOP, NSYMS, cdf_data, out_ready,
    input  in_ready, cdf_rd_en, cdf_addr, out_valid, out_symbol, out_u, out_v, out_rng
  );
endinterface

// File: rtl/symbol_search_dec.sv
// rtl/symbol_search_dec.sv - AV1 multi-symbol search: walks the inverse CDF to find the decoded symbol
// One CDF entry is fetched and compared every two cycles; all outputs are registered.
module symbol_search_dec #(
  parameter int RANGE_WIDTH  = 16,
  parameter int SYMBOL_WIDTH = 4,
  parameter int CDF_WIDTH    = 16
) (
  input  logic                 clk_search,
  input  logic                 reset,
  symbol_search_dec_if.slave   bus
);
  localparam int PW = (RANGE_WIDTH - 8) + (CDF_WIDTH - 6);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPARE, S_DONE} state_t;

  state_t                  r_state;
  logic [RANGE_WIDTH-1:0]  r_rng;
  logic [RANGE_WIDTH-1:0]  r_dif;
  logic [RANGE_WIDTH-1:0]  r_u;
  logic [SYMBOL_WIDTH-1:0] r_n;
  logic [SYMBOL_WIDTH-1:0] r_idx;
  logic                    r_in_ready;
  logic                    r_cdf_rd_en;
  logic [SYMBOL_WIDTH-1:0] r_cdf_addr;
  logic                    r_out_valid;
  logic [SYMBOL_WIDTH-1:0] r_out_symbol;
  logic [RANGE_WIDTH-1:0]  r_out_u;
  logic [RANGE_WIDTH-1:0]  r_out_v;
  logic [RANGE_WIDTH-1:0]  r_out_rng;

  logic [SYMBOL_WIDTH:0]   w_nsyms_m1;
  logic [SYMBOL_WIDTH-1:0] w_n_in;
  logic [SYMBOL_WIDTH-1:0] w_idx_next;
  logic [SYMBOL_WIDTH-1:0] w_remain;
  logic [SYMBOL_WIDTH+1:0] w_bias;
  logic [RANGE_WIDTH-9:0]  w_rng_hi;
  logic [CDF_WIDTH-7:0]    w_cdf_hi;
  logic [PW-1:0]           w_prod;
  logic [PW-2:0]           w_sum;
  logic [RANGE_WIDTH-1:0]  w_v;
  logic                    w_match;
  logic                    w_accept;

  // N is NSYMS-1 truncated to the symbol width, matching the encoder side
  assign w_nsyms_m1 = bus.NSYMS - (SYMBOL_WIDTH + 1)'(1);
  assign w_n_in     = w_nsyms_m1[SYMBOL_WIDTH-1:0];
  assign w_idx_next = r_idx + SYMBOL_WIDTH'(1);
  assign w_accept   = (r_state == S_IDLE) && bus.in_valid && r_in_ready;

  // v = ((rng>>8 * cdf>>6) >> 1) + 4*(N-idx); always below the range, so 16b suffices
  assign w_rng_hi = r_rng[RANGE_WIDTH-1:8];
  assign w_cdf_hi = bus.cdf_data[CDF_WIDTH-1:6];
  assign w_prod   = PW'(w_rng_hi) * PW'(w_cdf_hi);
  assign w_remain = r_n - r_idx;
  assign w_bias   = {w_remain, 2'b00};
  assign w_sum    = w_prod[PW-1:1] + (PW-1)'(w_bias);
  assign w_v      = w_sum[RANGE_WIDTH-1:0];
  assign w_match  = (r_dif >= w_v);

  always_ff @(posedge clk_search or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rng        <= '0;
      r_dif        <= '0;
      r_u          <= '0;
      r_n          <= '0;
      r_idx        <= '0;
      r_in_ready   <= 1'b0;
      r_cdf_rd_en  <= 1'b0;
      r_cdf_addr   <= '0;
      r_out_valid  <= 1'b0;
      r_out_symbol <= '0;
      r_out_u      <= '0;
      r_out_v      <= '0;
      r_out_rng    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_rng      <= bus.RNG;
            r_dif      <= bus.DIF_TOP;
            r_u        <= bus.RNG;
            r_n        <= w_n_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_FETCH;
            // the read strobe is registered on entry so it is high for the whole FETCH cycle
            if (w_n_in != '0) begin
              r_cdf_rd_en <= 1'b1;
              r_cdf_addr  <= '0;
            end
          end
        end
        S_FETCH: begin
          r_cdf_rd_en <= 1'b0;
          if (r_idx == r_n) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_out_symbol <= r_idx;
            r_out_u      <= r_u;
            r_out_v      <= '0;
            r_out_rng    <= r_u;
          end else begin
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (w_match) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_out_symbol <= r_idx;
            r_out_u      <= r_u;
            r_out_v      <= w_v;
            r_out_rng    <= r_u - w_v;
          end else begin
            r_u     <= w_v;
            r_idx   <= w_idx_next;
            r_state <= S_FETCH;
            if (w_idx_next != r_n) begin
              r_cdf_rd_en <= 1'b1;
              r_cdf_addr  <= w_idx_next;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.cdf_rd_en  = r_cdf_rd_en;
  assign bus.cdf_addr   = r_cdf_addr;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_symbol = r_out_symbol;
  assign bus.out_u      = r_out_u;
  assign bus.out_v      = r_out_v;
  assign bus.out_rng    = r_out_rng;
endmodule

// File: tb/tb_symbol_search_dec.sv
// tb/tb_symbol_search_dec.sv - randomized bench for symbol_search_dec against a behavioural search model
module tb_symbol_search_dec;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  symbol_search_dec_if bus ();
  symbol_search_dec dut (.clk_search(clk), .reset(rst_n), .bus(bus));

  logic [15:0] cdf_mem [16];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rd_total = 0;
  int   acc_cyc = 0;
  int   rd_base = 0;
  int   exp_sym = 0;
  int   exp_cycle = 0;
  int   exp_reads = 0;
  logic [15:0] exp_u = '0;
  logic [15:0] exp_v = '0;
  bit   armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // CDF memory: one-cycle read latency
  always @(posedge clk) if (bus.cdf_rd_en) bus.cdf_data <= cdf_mem[bus.cdf_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference: linear search of the inverse CDF with plain integer arithmetic
  task automatic model(input int rng, input int dif, input int nsyms);
    int n, u, v;
    n = (nsyms - 1) & 15;
    u = rng;
    exp_sym = n;
    exp_u = u[15:0];
    exp_v = '0;
    for (int i = 0; i < n; i++) begin
      v = ((((rng / 256) * (int'(cdf_mem[i]) / 64)) / 2) + 4 * (n - i)) % 65536;
      if (dif >= v) begin
        exp_sym = i;
        exp_u = u[15:0];
        exp_v = v[15:0];
        break;
      end
      u = v;
      exp_u = u[15:0];
    end
    exp_cycle = (exp_sym < n) ? 2 * exp_sym + 3 : 2 * n + 2;
    exp_reads = (exp_sym < n) ? exp_sym + 1 : n;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (bus.cdf_rd_en) begin
        chk("rd_addr", 32'(bus.cdf_addr), rd_total - rd_base);
        chk("rd_cycle", cyc - acc_cyc + 1, 2 * (rd_total - rd_base) + 1);
        rd_total <= rd_total + 1;
      end
      if (bus.out_valid) begin
        chk("out_symbol", 32'(bus.out_symbol), exp_sym);
        chk("out_u", 32'(bus.out_u), 32'(exp_u));
        chk("out_v", 32'(bus.out_v), 32'(exp_v));
        chk("out_rng", 32'(bus.out_rng), 32'(16'(exp_u - exp_v)));
        chk("done_in_ready", 32'(bus.in_ready), 0);
        chk("done_rd_en", 32'(bus.cdf_rd_en), 0);
      end
    end
  end

  task automatic start_req(input int rng, input int dif, input int nsyms, input bit ready_now);
    int n;
    model(rng, dif, nsyms);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(bus.in_ready), 1);
    bus.RNG = rng[15:0];
    bus.DIF_TOP = dif[15:0];
    bus.NSYMS = nsyms[4:0];
    bus.in_valid = 1'b1;
    bus.out_ready = ready_now;
    acc_cyc = cyc + 1;
    rd_base = rd_total;
    armed = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.RNG = 16'($urandom);
    bus.DIF_TOP = 16'($urandom);
    bus.NSYMS = 5'($urandom);
  endtask

  task automatic finish_req(input int hold);
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      chk("busy_in_ready", 32'(bus.in_ready), 0);
    end
    chk("valid_seen", 32'(bus.out_valid), 1);
    chk("valid_cycle", cyc - acc_cyc + 1, exp_cycle);
    chk("read_count", rd_total - rd_base, exp_reads);
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", 32'(bus.out_valid), 0);
    chk("ready_back", 32'(bus.in_ready), 1);
    armed = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_rd_en"}, 32'(bus.cdf_rd_en), 0);
    chk({tag, "_addr"}, 32'(bus.cdf_addr), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_symbol"}, 32'(bus.out_symbol), 0);
    chk({tag, "_u"}, 32'(bus.out_u), 0);
    chk({tag, "_v"}, 32'(bus.out_v), 0);
    chk({tag, "_rng"}, 32'(bus.out_rng), 0);
  endtask

  task automatic set_quad_cdf();
    cdf_mem[0] = 16'd24576;
    cdf_mem[1] = 16'd16384;
    cdf_mem[2] = 16'd8192;
    cdf_mem[3] = 16'd0;
  endtask

  task automatic random_cdf();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) cdf_mem[i] = 16'($urandom_range(32767, 0));
    for (int i = 0; i < 15; i++)
      for (int j = 0; j < 15 - i; j++)
        if (cdf_mem[j] < cdf_mem[j + 1]) begin
          t = cdf_mem[j];
          cdf_mem[j] = cdf_mem[j + 1];
          cdf_mem[j + 1] = t;
        end
  endtask

  initial begin
    int rng, dif, ns, hold;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.RNG = '0;
    bus.DIF_TOP = '0;
    bus.NSYMS = '0;
    bus.cdf_data = '0;
    for (int i = 0; i < 16; i++) cdf_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.in_ready), 1);

    cdf_mem[0] = 16'd16384;
    start_req(32768, 20000, 2, 1'b1);
    chk("pin_bin0_sym", exp_sym, 0);
    chk("pin_bin0_v", 32'(exp_v), 16388);
    chk("pin_bin0_cycle", exp_cycle, 3);
    finish_req(0);

    start_req(32768, 10000, 2, 1'b1);
    chk("pin_bin1_sym", exp_sym, 1);
    chk("pin_bin1_u", 32'(exp_u), 16388);
    chk("pin_bin1_cycle", exp_cycle, 4);
    finish_req(0);

    set_quad_cdf();
    start_req(65535, 20000, 4, 1'b1);
    chk("pin_quad_sym", exp_sym, 2);
    chk("pin_quad_u", 32'(exp_u), 32648);
    chk("pin_quad_v", 32'(exp_v), 16324);
    chk("pin_quad_cycle", exp_cycle, 7);
    finish_req(0);

    start_req(65535, 20000, 4, 1'b0);
    finish_req(5);

    start_req(65535, 20000, 4, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    armed = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", 32'(bus.in_ready), 1);

    cdf_mem[0] = 16'd16384;
    start_req(32768, 20000, 2, 1'b1);
    finish_req(0);

    rng = $urandom_range(65535, 32768);
    start_req(rng, $urandom_range(65535, 0), 1, 1'b1);
    chk("pin_deg_u", 32'(exp_u), rng);
    chk("pin_deg_cycle", exp_cycle, 2);
    finish_req(0);

    for (int k = 0; k < 4; k++) begin
      random_cdf();
      rng = $urandom_range(65535, 32768);
      start_req(rng, $urandom_range(rng - 1, 0), 16, 1'b1);
      finish_req(0);
    end

    for (int k = 0; k < 40; k++) begin
      random_cdf();
      ns = $urandom_range(16, 1);
      rng = $urandom_range(65535, 32768);
      dif = $urandom_range(rng - 1, 0);
      hold = $urandom_range(3, 0);
      start_req(rng, dif, ns, hold == 0);
      finish_req(hold);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/symbol_search_dec.md
# symbol_search_dec

Multi-symbol search stage of the AV1 entropy decoder. It is the decode-side counterpart of the encoder's first stage.
- The encoder maps a symbol to FL/FH and scaled range bounds.
- This block maps a range and the top 16 bits of the decoder window back to a symbol. It walks the inverse CDF one entry per two cycles through a one-cycle-latency CDF memory.
- It sits between the window/normalization register stage (upstream) and the range/dif update stage (downstream).

## Interface
- RANGE_WIDTH, 16, width of range, window compare value and u/v
- SYMBOL_WIDTH, 4, symbol index width; NSYMS is SYMBOL_WIDTH+1 bits
- CDF_WIDTH, 16, width of one inverse-CDF entry (Q15)

Ports:
- clk_search  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block idle, request accepted when in_valid & in_ready
- RNG  in  RANGE_WIDTH  current range, normalized (32768..65535)
- DIF_TOP  in  RANGE_WIDTH  top 16 bits of the dif window (c)
- NSYMS  in  SYMBOL_WIDTH+1  alphabet size (1..16)
- cdf_rd_en  out  1  CDF memory read strobe
- cdf_addr  out  SYMBOL_WIDTH  CDF entry index
- cdf_data  in  CDF_WIDTH  inverse-CDF entry, valid the cycle after cdf_rd_en
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_symbol  out  SYMBOL_WIDTH  decoded symbol
- out_u, out_v  out  RANGE_WIDTH  interval bounds for the decoded symbol
- out_rng  out  RANGE_WIDTH  new range, out_u - out_v (pre-normalization)

## Operation
- On accept, capture RNG, DIF_TOP and N, where N = (NSYMS-1)[SYMBOL_WIDTH-1:0]. The truncation is the same as on the encoder side.
- On accept, also set idx=0 and u=RNG.
- FSM states: IDLE, FETCH, COMPARE, DONE.
- **IDLE:** in_ready=1. On accept, go to FETCH.
- **FETCH, idx<N:** cdf_rd_en=1 and cdf_addr=idx, then go to COMPARE.
- **FETCH, idx==N:** do not read. Set v=0 and go to DONE. This is the last symbol, which always matches.
- **COMPARE:** compute v = (((RNG>>8) * (cdf_data>>6)) >> 1) + 4*(N-idx).
  - Multiply is 8b x 10b = 18b. After the shift it is 17b; the sum is held in 17b. The result is always < RNG, so it is truncated to 16b.
  - If DIF_TOP >= v (unsigned): go to DONE with symbol=idx.
  - Else: u<=v, idx<=idx+1, go to FETCH.
- **DONE:** out_valid=1. out_symbol, out_u, out_v and out_rng are stable. When out_ready=1, go to IDLE.
- cdf_rd_en is 0 outside FETCH. cdf_addr holds its last value.
- in_valid is ignored outside IDLE. Inputs are sampled only at accept and may change afterwards.

## Timing
- All outputs are registered.
- Reset values: in_ready=0 (set to 1 on the first clock edge after reset release), cdf_rd_en=0, cdf_addr=0, out_valid=0, out_symbol=0, out_u=0, out_v=0, out_rng=0. State=IDLE.
- Define the accept edge as cycle 0.
- For symbol s<N: reads occur in cycles 1,3,…,2s+1, and out_valid rises in cycle 2s+3.
- For symbol s=N: out_valid rises in cycle 2N+2.
- in_ready is 0 from cycle 1 until the cycle after the out_valid&out_ready edge. Minimum request spacing is 2s+4 cycles.
- Backpressure: with out_ready=0, DONE is held indefinitely with outputs frozen. No CDF reads are issued.
- NSYMS=1 (N=0): no read is issued. Result is symbol 0, u=RNG, v=0, out_valid in cycle 2.
- Reset asserted in any state: immediately return to IDLE with reset values. Any in-flight read result is discarded.

## Test plan
- **Binary, symbol 0:** NSYMS=2, RNG=32768, cdf[0]=16384, DIF_TOP=20000 -> symbol 0, u=32768, v=16388, rng=16380; one read at addr 0; out_valid at cycle 3.
- **Binary, last symbol:** NSYMS=2, RNG=32768, cdf[0]=16384, DIF_TOP=10000 -> symbol 1, u=16388, v=0, rng=16388; one read; out_valid at cycle 4.
- **4-ary:** NSYMS=4, RNG=65535, cdf={24576,16384,8192,0}, DIF_TOP=20000 -> v sequence 48972, 32648, 16324 -> symbol 2, u=32648, v=16324, rng=16324; reads at addr 0,1,2 in cycles 1,3,5; out_valid at cycle 7.
- **Backpressure:** repeat the 4-ary case with out_ready=0 for 5 cycles after out_valid -> outputs constant, in_ready=0, cdf_rd_en=0; the cycle after out_ready=1, in_ready=1 and out_valid=0.
- **Reset mid-search:** pull reset low in cycle 3 of the 4-ary case -> all outputs reset values immediately; after release, in_ready=1 on the first edge; a new binary request then decodes correctly.
- **Degenerate and back-to-back:** NSYMS=1 with any RNG -> symbol 0, v=0, out_rng=RNG, no read. Then 16-symbol requests with out_ready tied high -> in_ready reasserts exactly 1 cycle after each result handshake.
